// File: rtl/apb_cmd_master.sv
// APB3 requester: turns a valid/ready command stream into single APB transfers
// and returns read data / error / timeout on a valid/ready response channel.
module apb_cmd_master #(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    input  logic              cmd_write,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [AWIDTH-1:0] paddr,
    output logic [DWIDTH-1:0] pwdata,
    input  logic [DWIDTH-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    output logic [1:0]        o_dbg_state
);

    // Handshakes: a beat transfers on a rising edge where valid & ready are both 1;
    // rsp_* stay stable while rsp_valid is high and rsp_ready is low.

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam int              CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              TO_EN    = (TIMEOUT != 0);
    localparam logic [CW-1:0]   CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0]   CNT_MAX  = '1;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_alive;
    logic [AWIDTH-1:0] r_paddr;
    logic [DWIDTH-1:0] r_pwdata;
    logic              r_pwrite;
    logic [DWIDTH-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;
    logic              w_cmd_ready;
    logic              w_timeout_hit;

    // r_alive keeps cmd_ready low while reset is held and until the first edge after release.
    assign w_cmd_ready   = (r_state == S_IDLE) && r_alive;
    assign w_timeout_hit = TO_EN && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_alive       <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pwrite      <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && w_cmd_ready) begin
                        r_paddr  <= cmd_addr;
                        r_pwdata <= cmd_wdata;
                        r_pwrite <= cmd_write;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_cnt   <= '0;
                    r_state <= S_ACCESS;
                end
                S_ACCESS: begin
                    // A completing pready takes priority over a timeout in the same cycle.
                    if (pready) begin
                        r_rsp_rdata   <= r_pwrite ? '0 : prdata;
                        r_rsp_err     <= pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= S_RESP;
                    end else if (w_timeout_hit) begin
                        r_rsp_rdata   <= '0;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_state       <= S_RESP;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready   = w_cmd_ready;
    assign psel        = (r_state == S_SETUP) || (r_state == S_ACCESS);
    assign penable     = (r_state == S_ACCESS);
    assign rsp_valid   = (r_state == S_RESP);
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign pwrite      = r_pwrite;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: bench-side APB slave with programmable wait states,
// transaction-level reference model and response scoreboard.
module tb_apb_cmd_master;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          cmd_write;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic [1:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    int            slv_waits = 0;
    logic [DW-1:0] slv_rdata = '0;
    logic          slv_err   = 1'b0;
    int            acc_cnt;
    logic [DW-1:0] noise_d = '0;
    logic          noise_e = 1'b0;

    logic [DW+1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    apb_cmd_master #(.DWIDTH(DW), .AWIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_write(cmd_write),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .o_dbg_state(dbg_state)
    );

    // ---------------- APB slave: pready after slv_waits wait states ----------------
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_cnt <= 0;
        else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    always @(posedge clk) begin
        noise_d <= $urandom;
        noise_e <= 1'($urandom_range(0, 1));
    end

    always_comb begin
        pready  = psel && penable && (acc_cnt == slv_waits);
        prdata  = pready ? slv_rdata : noise_d;
        pslverr = pready ? slv_err : noise_e;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_times_out(input int waits);
        return (TO != 0) && (waits >= TO);
    endfunction

    // cycle offset (from the accepting edge) in which rsp_valid is first seen
    function automatic int model_latency(input int waits);
        if (model_times_out(waits)) return 2 + TO;
        return 3 + waits;
    endfunction

    function automatic logic [DW+1:0] model_rsp(input logic w, input int waits,
                                                input logic [DW-1:0] rd, input logic se);
        if (model_times_out(waits)) return {{DW{1'b0}}, 1'b1, 1'b1};
        return {(w ? {DW{1'b0}} : rd), se, 1'b0};
    endfunction

    // ---------------- driver ----------------
    task automatic run_xfer(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w,
                            input int waits, input logic [DW-1:0] rd, input logic se,
                            input int bp, input logic keep_valid);
        int            lat;
        bit            acc;
        logic [DW+1:0] exp;
        lat = model_latency(waits);
        exp_q.push_back(model_rsp(w, waits, rd, se));
        slv_waits = waits;
        slv_rdata = rd;
        slv_err   = se;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_write = w;
        rsp_ready = (bp == 0);
        acc = 0;
        for (int i = 0; i < 8 && !acc; i++) begin
            @(negedge clk);
            if (cmd_ready) acc = 1;
        end
        check_eq("cmd_accept", 64'(acc), 1);
        @(posedge clk); #1;
        cmd_valid = keep_valid;
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
        cmd_write = 1'($urandom_range(0, 1));
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check_eq("psel", 64'(psel), 1);
            check_eq("penable", 64'(penable), 64'(k >= 2));
            check_eq("rsp_valid_early", 64'(rsp_valid), 0);
            check_eq("cmd_ready_busy", 64'(cmd_ready), 0);
            check_eq("paddr", 64'(paddr), 64'(a));
            check_eq("pwdata", 64'(pwdata), 64'(d));
            check_eq("pwrite", 64'(pwrite), 64'(w));
        end
        exp = exp_q.pop_front();
        for (int c = 0; c <= bp; c++) begin
            @(negedge clk);
            check_eq("rsp_valid", 64'(rsp_valid), 1);
            check_eq("psel_resp", 64'(psel), 0);
            check_eq("penable_resp", 64'(penable), 0);
            check_eq("cmd_ready_resp", 64'(cmd_ready), 0);
            check_eq("rsp_rdata", 64'(rsp_rdata), 64'(exp[DW+1:2]));
            check_eq("rsp_err", 64'(rsp_err), 64'(exp[1]));
            check_eq("rsp_timeout", 64'(rsp_timeout), 64'(exp[0]));
            rsp_ready = (c == bp);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("rsp_released", 64'(rsp_valid), 0);
        check_eq("cmd_ready_again", 64'(cmd_ready), 1);
        check_eq("paddr_hold", 64'(paddr), 64'(a));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_write = 1'b0;
        rsp_ready = 1'b0;

        // reset with random inputs: every output held at 0
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_addr  = AW'($urandom);
            cmd_wdata = $urandom;
            cmd_write = 1'($urandom_range(0, 1));
            rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_eq("rst_cmd_ready", 64'(cmd_ready), 0);
            check_eq("rst_psel", 64'(psel), 0);
            check_eq("rst_penable", 64'(penable), 0);
            check_eq("rst_pwrite", 64'(pwrite), 0);
            check_eq("rst_paddr", 64'(paddr), 0);
            check_eq("rst_pwdata", 64'(pwdata), 0);
            check_eq("rst_rsp_valid", 64'(rsp_valid), 0);
            check_eq("rst_rsp_rdata", 64'(rsp_rdata), 0);
            check_eq("rst_rsp_err", 64'(rsp_err), 0);
            check_eq("rst_rsp_timeout", 64'(rsp_timeout), 0);
        end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("post_rst_cmd_ready", 64'(cmd_ready), 1);
        check_eq("post_rst_psel", 64'(psel), 0);

        // directed: zero-wait write, 3-wait read with slave error
        run_xfer(10'h010, 32'hDEAD_BEEF, 1'b1, 0, 32'hCAFE_F00D, 1'b0, 0, 1'b0);
        run_xfer(10'h3FC, 32'h0BAD_0BAD, 1'b0, 3, 32'h1234_5678, 1'b1, 0, 1'b0);

        // timeout (slave never ready), then ready in the last allowed ACCESS cycle
        run_xfer(10'h155, 32'h1111_2222, 1'b0, 1000, 32'hAAAA_5555, 1'b0, 0, 1'b0);
        run_xfer(10'h0AA, 32'h3333_4444, 1'b0, TO - 1, 32'h5A5A_A5A5, 1'b0, 0, 1'b0);
        run_xfer(10'h2AA, 32'h5555_6666, 1'b1, TO, 32'h7777_8888, 1'b1, 0, 1'b0);

        // response backpressure with cmd_valid held, then a second command
        run_xfer(10'h123, 32'h9999_AAAA, 1'b0, 1, 32'h0F0F_F0F0, 1'b0, 5, 1'b1);
        run_xfer(10'h321, 32'hBBBB_CCCC, 1'b1, 2, 32'h0, 1'b1, 0, 1'b0);

        // reset in the middle of ACCESS: transfer dropped, no response
        slv_waits = 1000;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = 10'h0F0;
        cmd_wdata = 32'h0102_0304;
        cmd_write = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        check_eq("mid_psel_before_rst", 64'(psel), 1);
        check_eq("mid_penable_before_rst", 64'(penable), 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_psel", 64'(psel), 0);
        check_eq("mid_rst_penable", 64'(penable), 0);
        check_eq("mid_rst_rsp_valid", 64'(rsp_valid), 0);
        check_eq("mid_rst_cmd_ready", 64'(cmd_ready), 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("mid_post_cmd_ready", 64'(cmd_ready), 1);
        check_eq("mid_post_rsp_valid", 64'(rsp_valid), 0);
        run_xfer(10'h0F4, 32'h5566_7788, 1'b1, 0, 32'h0, 1'b0, 0, 1'b0);

        // randomized transfers
        for (int t = 0; t < 25; t++) begin
            int waits;
            waits = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TO - 1, TO + 3))
                                                : int'($urandom_range(0, 5));
            run_xfer(AW'($urandom), $urandom, 1'($urandom_range(0, 1)), waits, $urandom,
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)));
        end

        check_eq("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
